// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-synchronous capture,
// inter-digit blanking, 16-level PWM brightness and optional leading-zero suppression.
module hex_display_scanner #(
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] data,
  input  logic        blank_lz,
  input  logic [3:0]  brightness,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        frame_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD_END  = SW'(DEAD_CYCLES);

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    anodes_q, anodes_d;
  logic [6:0]    segments_q, segments_d;
  logic          frame_tick_q, frame_tick_d;
  logic          capture_s;
  logic          on_s;
  logic [3:0]    nibble_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      4'hF:    seg = 7'h47;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // A digit is dark when it and every digit to its left hold zero; digit 0 always shows.
  function automatic logic blank_digit(input logic [1:0] k, input logic [15:0] v,
                                       input logic en);
    logic b;
    case (k)
      2'd1:    b = en && (v[15:4]  == 12'h000);
      2'd2:    b = en && (v[15:8]  == 8'h00);
      2'd3:    b = en && (v[15:12] == 4'h0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] pick_nibble(input logic [1:0] k, input logic [15:0] v);
    logic [3:0] n;
    case (k)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Scan counters and shadow capture
  always_comb begin
    capture_s = (digit_q == 2'd0) && (slot_cnt_q == '0);
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end else begin
      slot_cnt_d = slot_cnt_q + SW'(1);
      digit_d    = digit_q;
    end
    if (capture_s) begin
      shadow_d = data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Output decode; segments are gated with the anode so they only change while dark
  always_comb begin
    nibble_s     = pick_nibble(digit_q, shadow_q);
    on_s         = (slot_cnt_q >= DEAD_END) && (pwm_cnt_q <= brightness) &&
                   !blank_digit(digit_q, shadow_q, blank_lz);
    frame_tick_d = capture_s;
    if (on_s) begin
      anodes_d   = 4'b0001 << digit_q;
      segments_d = hex7(nibble_s);
    end else begin
      anodes_d   = 4'b0000;
      segments_d = 7'h00;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt_q   <= '0;
      digit_q      <= 2'd0;
      pwm_cnt_q    <= 4'd0;
      shadow_q     <= 16'h0000;
      anodes_q     <= 4'b0000;
      segments_q   <= 7'h00;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_q      <= digit_d;
      pwm_cnt_q    <= pwm_cnt_d;
      shadow_q     <= shadow_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign anodes     = anodes_q;
  assign segments   = segments_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench: an 8-cycle-slot scanner for frame/blanking/reset checks and a
// 64-cycle-slot scanner for PWM duty checks, both driven from the same inputs.
module tb_hex_display_scanner;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] data;
  logic        blank_lz;
  logic [3:0]  brightness;
  logic [3:0]  anodes, anodes64;
  logic [6:0]  segments, segments64;
  logic        frame_tick, frame_tick64;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  hex_display_scanner #(.SCAN_DIV(8), .DEAD_CYCLES(2)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .data(data), .blank_lz(blank_lz), .brightness(brightness),
    .anodes(anodes), .segments(segments), .frame_tick(frame_tick)
  );

  hex_display_scanner #(.SCAN_DIV(64), .DEAD_CYCLES(2)) u_dut64 (
    .CLK(CLK), .RST_N(RST_N), .data(data), .blank_lz(blank_lz), .brightness(brightness),
    .anodes(anodes64), .segments(segments64), .frame_tick(frame_tick64)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Continuous one-hot and dark-segment invariants while running
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      chk("onehot", {15'd0, ($countones(anodes) > 1)}, 16'd0);
      chk("onehot64", {15'd0, ($countones(anodes64) > 1)}, 16'd0);
      if (anodes == 4'b0000) chk("segdark", {9'd0, segments}, 16'd0);
    end
  end

  // Starts at the negedge where frame_tick is seen (index 0); ends at the next one.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input int chg_n, input logic [15:0] chg_val);
    logic [6:0] exp_seg [4];
    int d;
    int s;
    exp_seg = '{s0, s1, s2, s3};
    for (int n = 0; n < 32; n++) begin
      d = n / 8;
      s = n % 8;
      if (n > 0) @(negedge CLK);
      if (n == chg_n) data = chg_val;
      if (s >= 2 && exp_seg[d] != 7'h00) begin
        chk("anode", {12'd0, anodes}, 16'(1 << d));
        chk("seg", {9'd0, segments}, {9'd0, exp_seg[d]});
      end else begin
        chk("anode_off", {12'd0, anodes}, 16'd0);
        chk("seg_off", {9'd0, segments}, 16'd0);
      end
      if (n > 0) chk("ftick_low", {15'd0, frame_tick}, 16'd0);
    end
    @(negedge CLK);
    chk("ftick_period", {15'd0, frame_tick}, 16'd1);
  endtask

  task automatic wait_ft(input bit wide, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK);
      seen = wide ? frame_tick64 : frame_tick;
    end
    if (!seen) chk("ft_timeout", 16'd0, 16'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, {12'd0, anodes}, 16'd0);
    chk({tag, "_seg"}, {9'd0, segments}, 16'd0);
    chk({tag, "_ft"}, {15'd0, frame_tick}, 16'd0);
    chk({tag, "_an64"}, {12'd0, anodes64}, 16'd0);
  endtask

  initial begin
    logic [3:0] blev [3];
    int cnt;
    blev = '{4'd0, 4'd7, 4'd15};

    data       = 16'h1234;
    blank_lz   = 1'b0;
    brightness = 4'd15;
    RST_N      = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst_hold");

    // Release, first frame (1234) with data change at cycle 12, then ABCD frame
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rel_ft", {15'd0, frame_tick}, 16'd1);
    check_frame(7'h33, 7'h79, 7'h6D, 7'h30, 12, 16'hABCD);
    blank_lz = 1'b1;
    check_frame(7'h3D, 7'h4E, 7'h1F, 7'h77, 12, 16'h0050);
    check_frame(7'h7E, 7'h5B, 7'h00, 7'h00, 12, 16'h0000);
    check_frame(7'h7E, 7'h00, 7'h00, 7'h00, 12, 16'h1234);
    blank_lz = 1'b0;

    // PWM duty over 16 consecutive active cycles of digit 0
    for (int b = 0; b < 3; b++) begin
      brightness = blev[b];
      wait_ft(1'b1, 300);
      repeat (2) @(negedge CLK);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge CLK);
        if (anodes64 != 4'b0000) begin
          cnt++;
          chk("pwm_an", {12'd0, anodes64}, 16'h0001);
          chk("pwm_seg", {9'd0, segments64}, 16'h0033);
        end
      end
      chk("pwm_duty", 16'(cnt), 16'(blev[b]) + 16'd1);
    end
    brightness = 4'd15;

    // Reset at slot 5 of digit 2
    wait_ft(1'b0, 64);
    repeat (20) @(negedge CLK);
    chk("pre_rst_an", {12'd0, anodes}, 16'h0004);
    chk("pre_rst_seg", {9'd0, segments}, 16'h006D);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge CLK);
    check_reset_outputs("mid_hold");
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rerel_ft", {15'd0, frame_tick}, 16'd1);
    check_frame(7'h33, 7'h79, 7'h6D, 7'h30, -1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
